// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch: memory request FSM, prefetch buffer, branch/jump redirect
// Optional feature macro: IFU_PREFETCH_BUF_EN (two-entry prefetch buffer; one entry otherwise)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] instr_pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index
);

`ifdef IFU_PREFETCH_BUF_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       addr_q, addr_d;
  logic [1:0]        count_q, count_d;
  logic [1:0][31:0]  buf_instr_q, buf_instr_d;
  logic [1:0][31:0]  buf_pc_q, buf_pc_d;

  logic        req;
  logic        push;
  logic        pop;
  logic        redirect;
  logic [3:0]  jump_region;
  logic [31:0] redirect_target;
  logic [1:0]  widx;

  // Redirect decode: branch is older than the jump, so it wins; the jump keeps the
  // upper nibble of (jump pc + 4), computed as a carry into bits [31:28].
  always_comb begin
    pop             = (count_q != 2'd0) && instr_ready;
    redirect        = branch_taken || jump;
    jump_region     = buf_pc_q[0][31:28] + {3'b000, &buf_pc_q[0][27:2]};
    redirect_target = branch_taken ? branch_target : {jump_region, jump_index, 2'b00};
  end

  // Fetch FSM: issue a request only when the buffer has room; a redirect during an
  // outstanding request waits in DRAIN for its ack so the stale word is dropped.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    req        = 1'b0;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        if (count_q < DEPTH) begin
          req     = 1'b1;
          addr_d  = fetch_pc_q;
          state_d = redirect ? DRAIN : WAIT;
        end
      end
      WAIT: begin
        req = 1'b1;
        if (imem_ack) begin
          state_d = REQ;
          if (!redirect) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end else if (redirect) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        req = 1'b1;
        if (imem_ack) begin
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (redirect) begin
      fetch_pc_d = redirect_target;
    end
  end

  // Prefetch buffer: entry 0 is the head; pop shifts entry 1 down, push lands after
  // the surviving entries, and a redirect flushes everything.
  always_comb begin
    count_d     = count_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    widx        = count_q - {1'b0, pop};
    if (redirect) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        buf_instr_d[0] = buf_instr_q[1];
        buf_pc_d[0]    = buf_pc_q[1];
      end
      if (push) begin
        buf_instr_d[widx[0]] = imem_rdata;
        buf_pc_d[widx[0]]    = addr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // State register; reset overrides every handshake and redirect input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      addr_q      <= 32'd0;
      count_q     <= 2'd0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

  // Output drive: the address follows fetch_pc while issuing and is held from addr_q
  // for the rest of the request.
  always_comb begin
    imem_req    = req;
    imem_addr   = (state_q == REQ) ? fetch_pc_q : addr_q;
    instr_valid = (count_q != 2'd0);
    instr       = buf_instr_q[0];
    opcode      = buf_instr_q[0][31:26];
    instr_pc    = buf_pc_q[0];
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] instr_pc;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;

  int checks   = 0;
  int failures = 0;

  logic mem_hold;
  logic mem_force;
  int   mem_age;

`ifdef IFU_PREFETCH_BUF_EN
  localparam logic EXP_SECOND_READY = 1'b1;
`else
  localparam logic EXP_SECOND_READY = 1'b0;
`endif

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .opcode(opcode),
    .instr_pc(instr_pc), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index)
  );

  always #5 clk = ~clk;

  // Memory model: word at address a is ~a; ack one cycle after the request is seen.
  always @(negedge clk) begin
    if (mem_force) begin
      imem_ack   = 1'b1;
      imem_rdata = ~imem_addr;
      mem_age    = 0;
    end else if (imem_ack) begin
      imem_ack = 1'b0;
      mem_age  = imem_req ? 1 : 0;
    end else if (imem_req) begin
      mem_age    = mem_age + 1;
      imem_ack   = !mem_hold && (mem_age >= 2);
      imem_rdata = ~imem_addr;
    end else begin
      mem_age  = 0;
      imem_ack = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (instr_valid) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1; instr_ready = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    jump = 1'b0; jump_index = 26'd0; mem_hold = 1'b0; mem_force = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_imem_req got=%0b exp=0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid got=%0b exp=0", instr_valid); end
    checks++; if (instr !== 32'd0) begin failures++; $display("FAIL reset_instr got=%h exp=0", instr); end
    checks++; if (opcode !== 6'd0) begin failures++; $display("FAIL reset_opcode got=%h exp=0", opcode); end
    checks++; if (instr_pc !== 32'd0) begin failures++; $display("FAIL reset_instr_pc got=%h exp=0", instr_pc); end
    rst = 1'b0;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin failures++;
      $display("FAIL first_req got req=%0b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
  endtask

  task automatic test_sequential();
    int got = 0;
    logic [31:0] exp_pc, exp_instr;
    reset_dut();
    instr_ready = 1'b1;
    for (int c = 0; c < 60 && got < 4; c++) begin
      if (instr_valid) begin
        exp_pc = 32'(got) * 32'd4;
        exp_instr = ~exp_pc;
        checks++; if (instr_pc !== exp_pc) begin failures++; $display("FAIL seq_pc got=%h exp=%h", instr_pc, exp_pc); end
        checks++; if (instr !== exp_instr) begin failures++; $display("FAIL seq_instr got=%h exp=%h", instr, exp_instr); end
        checks++; if (opcode !== exp_instr[31:26]) begin failures++; $display("FAIL seq_opcode got=%h exp=%h", opcode, exp_instr[31:26]); end
        got++;
      end
      step();
    end
    checks++; if (got != 4) begin failures++; $display("FAIL seq_timeout got=%0d exp=4", got); end
    instr_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    reset_dut();
    wait_valid(30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_first_valid got=0 exp=1"); end
    checks++; if (instr_pc !== 32'd0 || instr !== 32'hFFFF_FFFF) begin failures++;
      $display("FAIL bp_first got pc=%h instr=%h exp pc=0 instr=ffffffff", instr_pc, instr); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'd0 || instr !== 32'hFFFF_FFFF || opcode !== 6'h3F) begin failures++;
        $display("FAIL bp_hold got v=%0b pc=%h instr=%h op=%h exp v=1 pc=0 instr=ffffffff op=3f", instr_valid, instr_pc, instr, opcode); end
    end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req_stop got=%0b exp=0", imem_req); end
    instr_ready = 1'b1;
    step();
    checks++; if (instr_valid !== EXP_SECOND_READY) begin failures++;
      $display("FAIL bp_second_buffered got=%0b exp=%0b", instr_valid, EXP_SECOND_READY); end
    wait_valid(30, ok);
    checks++; if (!ok || instr_pc !== 32'd4) begin failures++; $display("FAIL bp_second_pc got=%h exp=4", instr_pc); end
    instr_ready = 1'b0;
  endtask

  task automatic test_branch_wait();
    bit ok;
    reset_dut();
    mem_hold = 1'b1;
    step(); step();
    branch_taken = 1'b1; branch_target = 32'h40;
    step();
    branch_taken = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL br_valid got=%0b exp=0", instr_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin failures++;
      $display("FAIL br_drain got req=%0b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
    mem_hold = 1'b0;
    instr_ready = 1'b1;
    wait_valid(30, ok);
    checks++; if (!ok || instr_pc !== 32'h40) begin failures++; $display("FAIL br_target_pc got=%h exp=40", instr_pc); end
    checks++; if (instr !== 32'hFFFF_FFBF || opcode !== 6'h3F) begin failures++;
      $display("FAIL br_target_instr got=%h op=%h exp=ffffffbf op=3f", instr, opcode); end
    instr_ready = 1'b0;
  endtask

  task automatic test_jump();
    bit ok;
    reset_dut();
    branch_taken = 1'b1; branch_target = 32'h1000;
    step();
    branch_taken = 1'b0;
    wait_valid(30, ok);
    checks++; if (!ok || instr_pc !== 32'h1000) begin failures++; $display("FAIL jmp_setup_pc got=%h exp=1000", instr_pc); end
    jump = 1'b1; jump_index = 26'h10; instr_ready = 1'b1;
    step();
    jump = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL jmp_flush got=%0b exp=0", instr_valid); end
    wait_valid(30, ok);
    checks++; if (!ok || instr_pc !== 32'h40) begin failures++; $display("FAIL jmp_target got=%h exp=40", instr_pc); end
    instr_ready = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h1000;
    step();
    branch_taken = 1'b0;
    wait_valid(30, ok);
    checks++; if (!ok || instr_pc !== 32'h1000) begin failures++; $display("FAIL jmp_setup2_pc got=%h exp=1000", instr_pc); end
    jump = 1'b1; jump_index = 26'h10; branch_taken = 1'b1; branch_target = 32'h80; instr_ready = 1'b1;
    step();
    jump = 1'b0; branch_taken = 1'b0;
    wait_valid(30, ok);
    checks++; if (!ok || instr_pc !== 32'h80) begin failures++; $display("FAIL jmp_branch_prio got=%h exp=80", instr_pc); end
    instr_ready = 1'b0;
  endtask

  task automatic test_wrap();
    bit ok;
    reset_dut();
    instr_ready = 1'b1;
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    wait_valid(30, ok);
    checks++; if (!ok || instr_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_last_pc got=%h exp=fffffffc", instr_pc); end
    step();
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req) begin ok = 1'b1; break; end
      step();
    end
    checks++; if (!ok || imem_addr !== 32'd0) begin failures++; $display("FAIL wrap_addr got=%h exp=0", imem_addr); end
    wait_valid(30, ok);
    checks++; if (!ok || instr_pc !== 32'd0 || instr !== 32'hFFFF_FFFF) begin failures++;
      $display("FAIL wrap_next got pc=%h instr=%h exp pc=0 instr=ffffffff", instr_pc, instr); end
    instr_ready = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    reset_dut();
    mem_hold = 1'b1; instr_ready = 1'b1;
    step(); step();
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rw_wait_req got=%0b exp=1", imem_req); end
    rst = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
    step();
    rst = 1'b0; branch_taken = 1'b0; mem_force = 1'b1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rw_idle_req got=%0b exp=0", imem_req); end
    step();
    mem_force = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rw_stale_ack got=%0b exp=0", instr_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin failures++;
      $display("FAIL rw_restart got req=%0b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
    mem_hold = 1'b0;
    step();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rw_no_valid got=%0b exp=0", instr_valid); end
    wait_valid(30, ok);
    checks++; if (!ok || instr_pc !== 32'd0) begin failures++; $display("FAIL rw_first_pc got=%h exp=0", instr_pc); end
    instr_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instr_ready = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    jump = 1'b0; jump_index = 26'd0; mem_hold = 1'b0; mem_force = 1'b0; mem_age = 0;
    imem_ack = 1'b0; imem_rdata = 32'd0;
    step();
    test_reset();
    test_sequential();
    test_backpressure();
    test_branch_wait();
    test_jump();
    test_wrap();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
